// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the decode/issue stage: architectural widths,
// instruction field positions, opcode constants, the decoded-instruction
// struct, the ID/EXE entry struct and the decode function.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int OP_W      = 6;
  localparam int FUNC_W    = 6;

  // Instruction field positions.
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // Opcodes that change how the source/destination fields are used.
  localparam logic [OP_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OPC_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OPC_SW    = 6'h2B;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [FUNC_W-1:0]    func;
    logic [REG_IDX_W-1:0] dest;
    logic                 we;
    logic [XLEN-1:0]      imm;
    logic                 use1;
    logic                 use2;
  } dec_t;

  // Contents of the ID/EXE pipeline register (valid bit kept separately).
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      val1;
    logic [XLEN-1:0]      val2;
    logic [XLEN-1:0]      imm;
    logic [OP_W-1:0]      op;
    logic [FUNC_W-1:0]    func;
    logic [REG_IDX_W-1:0] dest;
    logic                 we;
  } idex_t;

  function automatic dec_t decode(input logic [XLEN-1:0] instr);
    dec_t d;
    d.op   = instr[OP_MSB:OP_LSB];
    d.func = instr[FUNC_MSB:FUNC_LSB];
    d.imm  = {{(XLEN-16){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    d.use1 = 1'b1;
    unique case (d.op)
      OPC_RTYPE: begin
        d.dest = instr[RD_MSB:RD_LSB];
        d.we   = 1'b1;
        d.use2 = 1'b1;
      end
      OPC_SW, OPC_BEQ, OPC_BNE: begin
        d.dest = '0;
        d.we   = 1'b0;
        d.use2 = 1'b1;
      end
      default: begin
        d.dest = instr[RT_MSB:RT_LSB];
        d.we   = 1'b1;
        d.use2 = 1'b0;
      end
    endcase
    // r0 is hard-wired, so writing it is never a pending write.
    if (d.dest == '0) d.we = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard
// Per-register pending-write counters (32 x 2 bit) and the RAW hazard query.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   inc_en/inc_idx      issue of an instruction that writes inc_idx
//   dec_en/dec_idx      write-back retiring a write to dec_idx (never r0)
//   kill_en/kill_idx    flushed ID/EXE entry whose write will never retire
//   q1_use/q1_idx       source 1 query
//   q2_use/q2_idx       source 2 query
//   hazard              a used source has an outstanding write
module id_scoreboard
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic [REG_IDX_W-1:0] inc_idx,
  input  logic                 dec_en,
  input  logic [REG_IDX_W-1:0] dec_idx,
  input  logic                 kill_en,
  input  logic [REG_IDX_W-1:0] kill_idx,
  input  logic                 q1_use,
  input  logic [REG_IDX_W-1:0] q1_idx,
  input  logic                 q2_use,
  input  logic [REG_IDX_W-1:0] q2_idx,
  output logic                 hazard
);

  logic [1:0] cnt_q [NUM_REGS];
  logic [1:0] cnt_d [NUM_REGS];

  // Increment, write-back decrement and kill decrement are summed per
  // register, so simultaneous events on one register net out correctly.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i]
               + 2'(inc_en  && (inc_idx  == REG_IDX_W'(i)))
               - 2'(dec_en  && (dec_idx  == REG_IDX_W'(i)))
               - 2'(kill_en && (kill_idx == REG_IDX_W'(i)));
    end
  end

  // NOTE: the counter array is architectural state (a stale count would
  // stall forever), so every entry is reset rather than left uninitialised.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A source whose only outstanding write retires this cycle is bypassed:
  // the register file writes on the falling edge, so read data is current.
  function automatic logic src_hazard(input logic                 use_src,
                                      input logic [REG_IDX_W-1:0] idx,
                                      input logic [1:0]           cnt,
                                      input logic                 wb_hit);
    logic bypass;
    bypass = (cnt == 2'd1) && wb_hit;
    return use_src && (idx != '0) && (cnt != 2'd0) && !bypass;
  endfunction

  logic h1;
  logic h2;

  always_comb begin
    h1     = src_hazard(q1_use, q1_idx, cnt_q[q1_idx], dec_en && (dec_idx == q1_idx));
    h2     = src_hazard(q2_use, q2_idx, cnt_q[q2_idx], dec_en && (dec_idx == q2_idx));
    hazard = h1 || h2;
  end

endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage
// Decode/issue stage: decodes the fetched instruction, drives register file
// read addresses, stalls on RAW hazards via the pending-write scoreboard and
// loads the ID/EXE pipeline register.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr/in_pc   fetch handshake
//   rf_src1/rf_src2, rf_reg1/rf_reg2   register file read addresses / data
//   wb_en/wb_dest                 write-back retirement
//   flush                         taken-branch kill from EXE
//   out_valid/out_ready           ID/EXE handshake
//   out_pc/out_val1/out_val2/out_imm/out_op/out_func/out_dest/out_we
//                                 ID/EXE entry contents
//   stall_count                   cycles with in_valid blocked (not flush)
module id_issue_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic [REG_IDX_W-1:0] rf_src1,
  output logic [REG_IDX_W-1:0] rf_src2,
  input  logic [XLEN-1:0]      rf_reg1,
  input  logic [XLEN-1:0]      rf_reg2,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_val1,
  output logic [XLEN-1:0]      out_val2,
  output logic [XLEN-1:0]      out_imm,
  output logic [OP_W-1:0]      out_op,
  output logic [FUNC_W-1:0]    out_func,
  output logic [REG_IDX_W-1:0] out_dest,
  output logic                 out_we,
  output logic [XLEN-1:0]      stall_count
);

  dec_t            dec;
  logic            hazard;
  logic            issue;
  logic            wb_dec;
  logic            kill_en;

  logic            out_valid_q, out_valid_d;
  idex_t           idex_q, idex_d;
  logic [XLEN-1:0] stall_count_q, stall_count_d;

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec     = decode(in_instr);
    rf_src1 = in_instr[RS_MSB:RS_LSB];
    rf_src2 = in_instr[RT_MSB:RT_LSB];
  end

  // ------------------------------------------------------------ scoreboard
  // The flushed entry's write will never reach write-back, so its pending
  // count is released here instead.
  assign wb_dec  = wb_en && (wb_dest != '0);
  assign kill_en = flush && out_valid_q && idex_q.we;

  id_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (issue && dec.we),
    .inc_idx  (dec.dest),
    .dec_en   (wb_dec),
    .dec_idx  (wb_dest),
    .kill_en  (kill_en),
    .kill_idx (idex_q.dest),
    .q1_use   (dec.use1),
    .q1_idx   (rf_src1),
    .q2_use   (dec.use2),
    .q2_idx   (rf_src2),
    .hazard   (hazard)
  );

  // ------------------------------------------------------------- handshake
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign issue    = in_valid && in_ready;

  // ------------------------------------------------------ ID/EXE register
  // NOTE: every variable is given a default at the top of the block so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    out_valid_d   = out_valid_q;
    idex_d        = idex_q;
    stall_count_d = stall_count_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
      idex_d.pc   = in_pc;
      idex_d.val1 = rf_reg1;
      idex_d.val2 = rf_reg2;
      idex_d.imm  = dec.imm;
      idex_d.op   = dec.op;
      idex_d.func = dec.func;
      idex_d.dest = dec.dest;
      idex_d.we   = dec.we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_valid && !in_ready && !flush) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      idex_q        <= '0;
      stall_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      idex_q        <= idex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = idex_q.pc;
  assign out_val1    = idex_q.val1;
  assign out_val2    = idex_q.val2;
  assign out_imm     = idex_q.imm;
  assign out_op      = idex_q.op;
  assign out_func    = idex_q.func;
  assign out_dest    = idex_q.dest;
  assign out_we      = idex_q.we;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage
// Directed bench for id_issue_stage: reset, independent back-to-back issue,
// RAW stall with same-cycle bypass, r0 destination, backpressure, flush
// under backpressure and reset during a stall.
module tb_id_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_src1, rf_src2;
  logic [31:0] rf_reg1, rf_reg2;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_val1, out_val2, out_imm;
  logic [5:0]  out_op, out_func;
  logic [4:0]  out_dest;
  logic        out_we;
  logic [31:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  // Hand-encoded instructions.
  localparam logic [31:0] ADD_R3_R1_R2  = 32'h0022_1820;
  localparam logic [31:0] ADD_R4_R5_R6  = 32'h00A6_2020;
  localparam logic [31:0] ADD_R4_R3_R3  = 32'h0063_2020;
  localparam logic [31:0] ADDI_R0_R1_5  = 32'h2020_0005;
  localparam logic [31:0] ADD_R2_R0_R0  = 32'h0000_1020;
  localparam logic [31:0] SW_R3_4_R1    = 32'hAC23_0004;
  localparam logic [31:0] ADDI_R7_R0_M1 = 32'h2007_FFFF;
  localparam logic [31:0] ADD_R8_R7_R0  = 32'h00E0_4020;
  localparam logic [31:0] ADD_R9_R8_R8  = 32'h0108_4820;

  id_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rf_src1     (rf_src1),
    .rf_src2     (rf_src2),
    .rf_reg1     (rf_reg1),
    .rf_reg2     (rf_reg2),
    .wb_en       (wb_en),
    .wb_dest     (wb_dest),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_val1    (out_val1),
    .out_val2    (out_val2),
    .out_imm     (out_imm),
    .out_op      (out_op),
    .out_func    (out_func),
    .out_dest    (out_dest),
    .out_we      (out_we),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [4:0] idx);
    wb_en   = 1'b1;
    wb_dest = idx;
    tick();
    wb_en   = 1'b0;
    wb_dest = '0;
  endtask

  // Scoreboard counters must stay within 0..3 on every update.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        int nv;
        nv = int'(dut.u_sb.cnt_q[i])
           + int'(dut.u_sb.inc_en  && (dut.u_sb.inc_idx  == 5'(i)))
           - int'(dut.u_sb.dec_en  && (dut.u_sb.dec_idx  == 5'(i)))
           - int'(dut.u_sb.kill_en && (dut.u_sb.kill_idx == 5'(i)));
        assert (nv >= 0 && nv <= 3) else begin
          n_err++;
          $error("FAIL sb_range r%0d: observed %0d expected 0..3", i, nv);
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    rf_reg1   = '0;
    rf_reg2   = '0;
    wb_en     = 1'b0;
    wb_dest   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // ---- reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_out_pc", out_pc, 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // ---- back-to-back independent
    in_valid = 1'b1; in_instr = ADD_R3_R1_R2; in_pc = 32'h100;
    rf_reg1 = 32'h11; rf_reg2 = 32'h22;
    #1;
    check("b2b_src1", rf_src1, 1);
    check("b2b_src2", rf_src2, 2);
    check("b2b_ready0", in_ready, 1);
    tick();
    check("b2b_valid0", out_valid, 1);
    check("b2b_dest0", out_dest, 3);
    check("b2b_we0", out_we, 1);
    check("b2b_val1", out_val1, 32'h11);
    check("b2b_val2", out_val2, 32'h22);
    check("b2b_pc0", out_pc, 32'h100);
    check("b2b_func0", out_func, 6'h20);
    in_instr = ADD_R4_R5_R6; in_pc = 32'h104;
    #1;
    check("b2b_ready1", in_ready, 1);
    tick();
    check("b2b_valid1", out_valid, 1);
    check("b2b_dest1", out_dest, 4);
    check("b2b_pc1", out_pc, 32'h104);
    check("b2b_cnt3", dut.u_sb.cnt_q[3], 1);
    in_valid = 1'b0;
    tick();
    check("b2b_drain", out_valid, 0);
    check("b2b_stalls", stall_count, 0);
    retire(5'd3);
    retire(5'd4);
    check("b2b_cnt3_clr", dut.u_sb.cnt_q[3], 0);
    check("b2b_cnt4_clr", dut.u_sb.cnt_q[4], 0);

    // ---- RAW hazard with same-cycle bypass release
    in_valid = 1'b1; in_instr = ADD_R3_R1_R2; in_pc = 32'h200;
    tick();
    in_instr = ADD_R4_R3_R3; in_pc = 32'h204;
    rf_reg1 = 32'hDEAD; rf_reg2 = 32'hBEEF;
    #1;
    check("raw_ready_blk", in_ready, 0);
    tick();
    check("raw_stall1", in_ready, 0);
    tick();
    check("raw_stall2", in_ready, 0);
    wb_en = 1'b1; wb_dest = 5'd3; rf_reg1 = 32'h55; rf_reg2 = 32'h55;
    #1;
    check("raw_ready_wb", in_ready, 1);
    tick();
    wb_en = 1'b0; wb_dest = '0; in_valid = 1'b0;
    check("raw_valid", out_valid, 1);
    check("raw_dest", out_dest, 4);
    check("raw_pc", out_pc, 32'h204);
    check("raw_val1", out_val1, 32'h55);
    check("raw_val2", out_val2, 32'h55);
    check("raw_stalls", stall_count, 2);
    check("raw_cnt3", dut.u_sb.cnt_q[3], 0);
    retire(5'd4);
    check("raw_cnt4", dut.u_sb.cnt_q[4], 0);

    // ---- r0 destination
    in_valid = 1'b1; in_instr = ADDI_R0_R1_5; in_pc = 32'h280;
    #1;
    check("r0_ready0", in_ready, 1);
    tick();
    check("r0_we", out_we, 0);
    check("r0_imm", out_imm, 32'h5);
    check("r0_op", out_op, 6'h08);
    in_instr = ADD_R2_R0_R0; in_pc = 32'h284;
    #1;
    check("r0_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("r0_dest2", out_dest, 2);
    check("r0_cnt0", dut.u_sb.cnt_q[0], 0);
    check("r0_stalls", stall_count, 2);
    retire(5'd2);

    // ---- backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = SW_R3_4_R1; in_pc = 32'h300;
    rf_reg1 = 32'hA1; rf_reg2 = 32'hB2;
    tick();
    check("bp_valid", out_valid, 1);
    check("bp_we", out_we, 0);
    check("bp_imm", out_imm, 32'h4);
    in_instr = ADD_R4_R5_R6; in_pc = 32'h304; rf_reg1 = 32'hC3; rf_reg2 = 32'hD4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", in_ready, 0);
      tick();
      check("bp_hold_pc", out_pc, 32'h300);
      check("bp_hold_val1", out_val1, 32'hA1);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_issue_pc", out_pc, 32'h304);
    check("bp_issue_dest", out_dest, 4);
    check("bp_stalls", stall_count, 5);
    tick();
    retire(5'd4);

    // ---- flush under backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ADDI_R7_R0_M1; in_pc = 32'h400;
    tick();
    in_valid = 1'b0;
    check("fl_valid", out_valid, 1);
    check("fl_dest", out_dest, 7);
    check("fl_we", out_we, 1);
    check("fl_imm", out_imm, 32'hFFFF_FFFF);
    check("fl_cnt7_pend", dut.u_sb.cnt_q[7], 1);
    flush = 1'b1;
    #1;
    check("fl_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("fl_killed", out_valid, 0);
    check("fl_cnt7", dut.u_sb.cnt_q[7], 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = ADD_R8_R7_R0; in_pc = 32'h404;
    #1;
    check("fl_reader_ready", in_ready, 1);
    tick();
    check("fl_reader_dest", out_dest, 8);
    check("fl_stalls", stall_count, 5);

    // ---- reset during a stall
    in_instr = ADD_R9_R8_R8; in_pc = 32'h408;
    #1;
    check("rs_blocked", in_ready, 0);
    tick();
    check("rs_stalls", stall_count, 6);
    #2;
    rst = 1'b0;
    #1;
    check("rs_valid", out_valid, 0);
    check("rs_stall_clr", stall_count, 0);
    check("rs_dest_clr", out_dest, 0);
    check("rs_cnt8", dut.u_sb.cnt_q[8], 0);
    tick();
    rst = 1'b1;
    #1;
    check("rs_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("rs_reissue_dest", out_dest, 9);
    check("rs_reissue_pc", out_pc, 32'h408);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
